// File: rtl/test_run_pkg.sv
// test_run_pkg: shared state encoding and result reason codes for the test run controller
package test_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } run_state_t;

    localparam logic [1:0] REASON_NONE    = 2'd0;
    localparam logic [1:0] REASON_PASS    = 2'd1;
    localparam logic [1:0] REASON_FAILURE = 2'd2;
    localparam logic [1:0] REASON_TIMEOUT = 2'd3;

endpackage

// File: rtl/test_run_cycle_counter.sv
// test_run_cycle_counter: saturating run cycle counter with clear and enable
module test_run_cycle_counter #(
    parameter int CYCLE_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [CYCLE_W-1:0] count
);

    // Clear together with enable lands on 1 so the first counted cycle of a run reads 1.
    always_ff @(posedge clock)
        if (!reset)
            count <= '0;
        else if (clear)
            count <= enable ? CYCLE_W'(1) : '0;
        else if (enable && !(&count))
            count <= count + CYCLE_W'(1);

endmodule

// File: rtl/test_run_controller.sv
// test_run_controller: sequences DUT reset, run, timeout and pass/fail reporting for one test run
module test_run_controller
    import test_run_pkg::*;
#(
    parameter int CYCLE_W      = 64,
    parameter int RESET_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CYCLE_W-1:0] max_cycles,
    input  logic [CYCLE_W-1:0] dump_start,
    input  logic               harness_success,
    input  logic               harness_failure,
    output logic               dut_reset,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               dump_en,
    output logic               running,
    output logic               done,
    output logic [1:0]         reason
);

    run_state_t         state;
    run_state_t         state_next;
    logic [CYCLE_W-1:0] max_q;
    logic [CYCLE_W-1:0] dump_start_q;
    logic [1:0]         reason_next;
    logic               accept;
    logic               timeout;
    logic               active_next;
    logic               dump_next;

    test_run_cycle_counter #(.CYCLE_W(CYCLE_W)) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (active_next),
        .count  (cycle_count)
    );

    // State register.
    always_ff @(posedge clock)
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;

    // Next state and result; the HOLD length reuses the run counter, which reads 1..RESET_CYCLES there.
    always_comb begin
        accept      = start && state != ST_HOLD && state != ST_RUN;
        timeout     = max_q != '0 && cycle_count > max_q;
        state_next  = state;
        reason_next = reason;
        case (state)
            ST_HOLD: state_next = cycle_count == CYCLE_W'(RESET_CYCLES) ? ST_RUN : ST_HOLD;
            ST_RUN: begin
                if (harness_failure || timeout) begin
                    state_next  = ST_FAIL;
                    reason_next = harness_failure ? REASON_FAILURE : REASON_TIMEOUT;
                end else if (harness_success) begin
                    state_next  = ST_PASS;
                    reason_next = REASON_PASS;
                end
            end
            default: begin
                state_next  = accept ? ST_HOLD : state;
                reason_next = accept ? REASON_NONE : reason;
            end
        endcase
        active_next = state_next == ST_HOLD || state_next == ST_RUN;
        dump_next   = accept ? (dump_start == '0 || dump_start == CYCLE_W'(1))
                             : active_next && (dump_en || cycle_count + CYCLE_W'(1) == dump_start_q);
    end

    // Latched run limits, result reason and dump window.
    always_ff @(posedge clock)
        if (!reset) begin
            max_q        <= '0;
            dump_start_q <= '0;
            reason       <= REASON_NONE;
            dump_en      <= 1'b0;
        end else begin
            reason  <= reason_next;
            dump_en <= dump_next;
            if (accept) begin
                max_q        <= max_cycles;
                dump_start_q <= dump_start;
            end
        end

    // Status outputs decoded from the registered state.
    always_comb begin
        running   = state == ST_HOLD || state == ST_RUN;
        done      = state == ST_PASS || state == ST_FAIL;
        dut_reset = state != ST_RUN;
    end

endmodule

// File: tb/tb_test_run_controller.sv
// tb_test_run_controller: scoreboard bench for test_run_controller with a run-outcome reference model
module tb_test_run_controller;

    localparam int W = 64;
    localparam int R = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         harness_success = 1'b0;
    logic         harness_failure = 1'b0;
    logic [W-1:0] max_cycles = '0;
    logic [W-1:0] dump_start = '0;
    logic         dut_reset;
    logic [W-1:0] cycle_count;
    logic         dump_en;
    logic         running;
    logic         done;
    logic [1:0]   reason;

    test_run_controller #(.CYCLE_W(W), .RESET_CYCLES(R)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .max_cycles      (max_cycles),
        .dump_start      (dump_start),
        .harness_success (harness_success),
        .harness_failure (harness_failure),
        .dut_reset       (dut_reset),
        .cycle_count     (cycle_count),
        .dump_en         (dump_en),
        .running         (running),
        .done            (done),
        .reason          (reason)
    );

    always #5 clock = ~clock;

    typedef struct {
        int mx;
        int ds;
        int s;
        int f;
        int stray;
    } run_t;

    typedef struct {
        int end_c;
        int rsn;
        int dfirst;
        int dcnt;
        int rlfirst;
        int rlcnt;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outcome of a run from the rules: HOLD covers counts 1..R, RUN starts at R+1,
    // failure beats timeout beats success, dump window spans max(ds,1)..end.
    function automatic exp_t model(input run_t r);
        exp_t e;
        int   first;
        e.end_c = 0;
        e.rsn   = 0;
        for (int c = R + 1; c <= 400; c++) begin
            if (r.f == c) begin e.end_c = c; e.rsn = 2; break; end
            if (r.mx != 0 && c > r.mx) begin e.end_c = c; e.rsn = 3; break; end
            if (r.s == c) begin e.end_c = c; e.rsn = 1; break; end
        end
        first    = r.ds == 0 ? 1 : r.ds;
        e.dfirst = first <= e.end_c ? first : 0;
        e.dcnt   = first <= e.end_c ? e.end_c - first + 1 : 0;
        e.rlfirst = R + 1;
        e.rlcnt   = e.end_c - R;
        return e;
    endfunction

    logic prev_run = 1'b0;
    logic prev_done = 1'b0;
    int   m_dcnt, m_dfirst, m_rlcnt, m_rlfirst;
    exp_t cur;

    always @(negedge clock) begin
        if (running && !prev_run) begin
            chk("first_count", cycle_count, 1);
            m_dcnt = 0; m_dfirst = 0; m_rlcnt = 0; m_rlfirst = 0;
        end
        if (running) begin
            if (dump_en) begin
                if (m_dcnt == 0) m_dfirst = int'(cycle_count);
                m_dcnt++;
            end
            if (!dut_reset) begin
                if (m_rlcnt == 0) m_rlfirst = int'(cycle_count);
                m_rlcnt++;
            end
        end
        if (done && !prev_done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got reason %0d expected no result", reason);
            end else begin
                cur = sbq.pop_front();
                chk("reason", reason, cur.rsn);
                chk("end_count", cycle_count, cur.end_c);
                chk("dump_first", m_dfirst, cur.dfirst);
                chk("dump_cycles", m_dcnt, cur.dcnt);
                chk("rst_low_first", m_rlfirst, cur.rlfirst);
                chk("rst_low_cycles", m_rlcnt, cur.rlcnt);
                chk("done_dump_en", dump_en, 0);
                chk("done_dut_reset", dut_reset, 1);
            end
        end else if (done && prev_done) begin
            chk("held_reason", reason, cur.rsn);
            chk("held_count", cycle_count, cur.end_c);
        end
        prev_run  = running;
        prev_done = done;
    end

    task automatic do_run(input run_t r);
        exp_t e;
        int   c;
        e = model(r);
        sbq.push_back(e);
        max_cycles = W'(r.mx);
        dump_start = W'(r.ds);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        max_cycles = {$urandom, $urandom};
        dump_start = {$urandom, $urandom};
        c = 1;
        while (!done && c < 300) begin
            harness_success = c == r.s;
            harness_failure = c == r.f;
            start = c == r.stray;
            @(negedge clock);
            c++;
        end
        harness_success = 1'b0;
        harness_failure = 1'b0;
        start = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got no done after %0d cycles expected done at count %0d", c, e.end_c);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_dut_reset"}, dut_reset, 1);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_dump_en"}, dump_en, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_reason"}, reason, 0);
    endtask

    initial begin
        run_t r;
        exp_t e;
        repeat (3) @(negedge clock);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clock);
        do_run('{0, 0, 10, 0, 0});
        do_run('{20, 0, 0, 0, 0});
        do_run('{0, 0, 8, 8, 0});
        do_run('{0, 0, 12, 2, 0});
        do_run('{0, 7, 12, 0, 0});
        do_run('{0, 1, 6, 0, 3});
        do_run('{0, 30, 6, 0, 0});
        do_run('{5, 0, 0, 0, 0});
        max_cycles = '0;
        dump_start = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_count", cycle_count, 6);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_idle("abort");
        @(negedge clock);
        chk("abort_idle_done", done, 0);
        do_run('{0, 3, 9, 0, 0});
        for (int i = 0; i < 30; i++) begin
            r.mx = $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(3, 30));
            r.ds = $urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 25));
            r.s  = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 35));
            r.f  = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 35)) : 0;
            if (r.mx == 0 && r.s <= R && r.f <= R) r.s = $urandom_range(R + 1, 30);
            r.stray = 0;
            e = model(r);
            if ($urandom_range(0, 1) == 1) r.stray = $urandom_range(1, e.end_c);
            do_run(r);
        end
        chk("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
